// File: rtl/pdl_pkg.sv
// Shared defaults and channel state encoding for the paddle timer bank.
// Tick counts assume a 50 MHz sys_clk (20 ns per tick).
package pdl_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_CNT_W       = 18;
    // 200 ticks = 4 us, 540 ticks = 10.8 us at 50 MHz
    localparam int unsigned DEF_BASE_TICKS  = 200;
    localparam int unsigned DEF_SLOPE_TICKS = 540;
    localparam int unsigned DEF_TICK_NS     = 20;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/pdl_channel.sv
// One paddle timer channel: loads BASE + value*SLOPE on an enabled trigger and
// holds pulse high for exactly that many cycles, with a done strobe on expiry.
module pdl_channel
    import pdl_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned BASE_TICKS  = DEF_BASE_TICKS,
    parameter int unsigned SLOPE_TICKS = DEF_SLOPE_TICKS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] val_i,
    output logic              pulse_o,
    output logic              done_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_n_s;
    logic             done_q, done_d;
    logic             pulse_q;

    assign load_n_s = CNT_W'(BASE_TICKS) + CNT_W'(val_i) * CNT_W'(SLOPE_TICKS);

    // Next-state: disable wins over retrigger; expiry at the last counted cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_i && en_i) begin
                    state_d = ST_RUN;
                    cnt_d   = load_n_s;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (trig_i) begin
                    state_d = ST_RUN;
                    cnt_d   = load_n_s;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pulse_q <= (state_d == ST_RUN);
        end
    end

    assign pulse_o = pulse_q;
    assign done_o  = done_q;

endmodule

// File: rtl/paddle_timer_bank.sv
// Bank of independent paddle timers sharing one trigger strobe; the top level
// only unpacks per-channel values and ORs the pulses into busy.
module paddle_timer_bank
    import pdl_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned BASE_TICKS  = DEF_BASE_TICKS,
    parameter int unsigned SLOPE_TICKS = DEF_SLOPE_TICKS,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     trigger,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_value,
    output logic [NUM_CH-1:0]        pulse,
    output logic [NUM_CH-1:0]        done,
    output logic                     busy
);

    // Longest load must fit the counter, and a zero-length pulse is meaningless
    localparam logic [63:0] MAX_N   = 64'(BASE_TICKS)
                                    + ((64'd1 << DATA_W) - 64'd1) * 64'(SLOPE_TICKS);
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    generate
        if ((MAX_N > CNT_MAX) || (BASE_TICKS == 0)) begin : g_bad_params
            $error("paddle_timer_bank: BASE_TICKS is 0 or maximum load exceeds CNT_W");
        end
    endgenerate

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            logic [DATA_W-1:0] val_s;
            assign val_s = ch_value[g*DATA_W +: DATA_W];

            pdl_channel #(
                .DATA_W      (DATA_W),
                .CNT_W       (CNT_W),
                .BASE_TICKS  (BASE_TICKS),
                .SLOPE_TICKS (SLOPE_TICKS)
            ) u_ch (
                .clk_i   (sys_clk),
                .rst_i   (reset),
                .trig_i  (trigger),
                .en_i    (ch_enable[g]),
                .val_i   (val_s),
                .pulse_o (pulse[g]),
                .done_o  (done[g])
            );
        end
    endgenerate

    assign busy = |pulse;

endmodule

// File: tb/tb_paddle_timer_bank.sv
// Self-checking bench for paddle_timer_bank: per-cycle scoreboard against a
// behavioural model, table-driven pulse-length vectors, and corner sequences.
module tb_paddle_timer_bank;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        trigger;
    logic [3:0]  ch_enable;
    logic [31:0] ch_value;
    logic [3:0]  pulse;
    logic [3:0]  done;
    logic        busy;

    logic        s_trigger;
    logic [0:0]  s_enable;
    logic [7:0]  s_value;
    logic [0:0]  s_pulse;
    logic [0:0]  s_done;
    logic        s_busy;

    always #5 sys_clk = ~sys_clk;

    paddle_timer_bank #(
        .NUM_CH(4), .DATA_W(8), .BASE_TICKS(200), .SLOPE_TICKS(540), .CNT_W(18)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .trigger(trigger), .ch_enable(ch_enable),
        .ch_value(ch_value), .pulse(pulse), .done(done), .busy(busy)
    );

    // Reduced-scale instance so the full-scale value 255 run stays short
    paddle_timer_bank #(
        .NUM_CH(1), .DATA_W(8), .BASE_TICKS(3), .SLOPE_TICKS(2), .CNT_W(10)
    ) dut_s (
        .sys_clk(sys_clk), .reset(reset), .trigger(s_trigger), .ch_enable(s_enable),
        .ch_value(s_value), .pulse(s_pulse), .done(s_done), .busy(s_busy)
    );

    int n_chk = 0;
    int n_err = 0;

    int m_rem  [4];
    bit m_run  [4];
    bit m_done [4];
    logic [8:0] sb_q [$];

    int len_c [4];
    int done_c [4];
    int first_c [4];
    int last_c [4];
    int done_at [4];
    int busy_c;
    int cyc = 0;

    typedef struct packed {
        logic [31:0]      val;
        logic [3:0]       en;
        logic [3:0][17:0] len;
        logic [3:0]       dn;
        logic [17:0]      busy_len;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                m_run[i] = 1'b0; m_rem[i] = 0; m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (m_run[i] && !ch_enable[i]) begin
                    m_run[i] = 1'b0; m_rem[i] = 0;
                end else if (trigger && ch_enable[i]) begin
                    m_run[i] = 1'b1;
                    m_rem[i] = 200 + int'(ch_value[i*8 +: 8]) * 540;
                end else if (m_run[i]) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_run[i] = 1'b0; m_done[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 4; i++) begin
            len_c[i] = 0; done_c[i] = 0; first_c[i] = -1; last_c[i] = -1; done_at[i] = -1;
        end
        busy_c = 0;
    endtask

    task automatic tick();
        logic [8:0] e;
        logic [8:0] got;
        model_step();
        e = {m_run[3], m_run[2], m_run[1], m_run[0],
             m_done[3], m_done[2], m_done[1], m_done[0],
             m_run[0] | m_run[1] | m_run[2] | m_run[3]};
        sb_q.push_back(e);
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
        got = {pulse, done, busy};
        e = sb_q.pop_front();
        check("scoreboard{pulse,done,busy}", int'(got), int'(e));
        for (int i = 0; i < 4; i++) begin
            if (pulse[i]) begin
                if (len_c[i] == 0) first_c[i] = cyc;
                last_c[i] = cyc;
                len_c[i]++;
            end
            if (done[i]) begin
                done_c[i]++;
                done_at[i] = cyc;
            end
        end
        if (busy) busy_c++;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((busy || m_run[0] || m_run[1] || m_run[2] || m_run[3]) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) begin
            n_chk++;
            n_err++;
            $display("FAIL run_idle_timeout: still busy after %0d cycles", n);
        end
        tick();
        tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int sp;
        int sd;
        vecs[0] = '{val: {8'd0, 8'd0, 8'd0, 8'd0}, en: 4'b0001,
                    len: {18'd0, 18'd0, 18'd0, 18'd200}, dn: 4'b0001, busy_len: 18'd200};
        vecs[1] = '{val: {8'd40, 8'd30, 8'd20, 8'd10}, en: 4'b1010,
                    len: {18'd21800, 18'd0, 18'd11000, 18'd0}, dn: 4'b1010, busy_len: 18'd21800};
        vecs[2] = '{val: {8'd3, 8'd0, 8'd2, 8'd1}, en: 4'b1111,
                    len: {18'd1820, 18'd200, 18'd1280, 18'd740}, dn: 4'b1111, busy_len: 18'd1820};
        vecs[3] = '{val: {8'd9, 8'd9, 8'd9, 8'd9}, en: 4'b0000,
                    len: {18'd0, 18'd0, 18'd0, 18'd0}, dn: 4'b0000, busy_len: 18'd0};

        for (int i = 0; i < 4; i++) begin
            m_rem[i] = 0; m_run[i] = 1'b0; m_done[i] = 1'b0;
        end
        reset = 1'b1; trigger = 1'b0; ch_enable = 4'b0000; ch_value = 32'd0;
        s_trigger = 1'b0; s_enable = 1'b0; s_value = 8'd0;
        clr_stats();
        @(negedge sys_clk);
        tick();
        tick();
        check("reset_pulse", int'(pulse), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        for (int r = 0; r < 4; r++) begin
            ch_value = vecs[r].val;
            ch_enable = vecs[r].en;
            clr_stats();
            trigger = 1'b1;
            tick();
            trigger = 1'b0;
            run_idle(25000);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("vec%0d_len_ch%0d", r, i), len_c[i], int'(vecs[r].len[i]));
                check($sformatf("vec%0d_done_ch%0d", r, i), done_c[i], int'(vecs[r].dn[i]));
                if (vecs[r].dn[i]) begin
                    check($sformatf("vec%0d_done_pos_ch%0d", r, i), done_at[i], last_c[i] + 1);
                    check($sformatf("vec%0d_contig_ch%0d", r, i),
                          last_c[i] - first_c[i] + 1, len_c[i]);
                end
            end
            check($sformatf("vec%0d_busy_len", r), busy_c, int'(vecs[r].busy_len));
        end

        // Retrigger ch0 at cycle 100 of a value-0 run with value 1
        ch_value = 32'd0; ch_enable = 4'b0001;
        clr_stats();
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (99) tick();
        ch_value[7:0] = 8'd1;
        trigger = 1'b1; tick(); trigger = 1'b0;
        rc = cyc;
        run_idle(2000);
        check("retrig_total_len", len_c[0], 840);
        check("retrig_contig", last_c[0] - first_c[0] + 1, 840);
        check("retrig_len_after", last_c[0] - rc + 1, 740);
        check("retrig_done_count", done_c[0], 1);

        // Reset at cycle 50 of a run
        ch_value = 32'd0; ch_enable = 4'b0001;
        clr_stats();
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (49) tick();
        reset = 1'b1; tick();
        check("rst_mid_pulse", int'(pulse[0]), 0);
        reset = 1'b0;
        repeat (210) tick();
        check("rst_mid_len", len_c[0], 50);
        check("rst_mid_done", done_c[0], 0);

        // Reset and trigger in the same cycle
        clr_stats();
        ch_enable = 4'b1111;
        reset = 1'b1; trigger = 1'b1; tick();
        reset = 1'b0; trigger = 1'b0;
        repeat (5) tick();
        check("rst_trig_busy", busy_c, 0);

        // Drop ch_enable[2] mid-run
        ch_value = {8'd0, 8'd5, 8'd0, 8'd0}; ch_enable = 4'b0100;
        clr_stats();
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (29) tick();
        ch_enable = 4'b0000; tick();
        check("en_drop_pulse", int'(pulse[2]), 0);
        run_idle(4000);
        check("en_drop_len", len_c[2], 30);
        check("en_drop_done", done_c[2], 0);

        // ch_value change during a run must not alter its length
        ch_value = 32'd0; ch_enable = 4'b0010;
        clr_stats();
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (9) tick();
        ch_value[15:8] = 8'd255;
        run_idle(1000);
        check("val_change_len", len_c[1], 200);
        check("val_change_done", done_c[1], 1);

        // Full-scale value on the reduced instance: 3 + 255*2 = 513 cycles
        s_value = 8'd255; s_enable = 1'b1; s_trigger = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        s_trigger = 1'b0;
        sp = 0; sd = 0;
        for (int k = 0; k < 1000; k++) begin
            if (s_pulse[0]) sp++;
            if (s_done[0]) sd++;
            @(posedge sys_clk); @(negedge sys_clk);
        end
        check("max_val_len", sp, 513);
        check("max_val_done", sd, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/paddle_timer_bank.md
PADDLE_TIMER_BANK -- requirements
Module: paddle_timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent paddle timer channels.
REQ-002 Parameter DATA_W, default 8, width of each channel's paddle value.
REQ-003 Parameter BASE_TICKS, default 200, pulse length for value 0 (4 us at 50 MHz).
REQ-004 Parameter SLOPE_TICKS, default 540, additional ticks per value step (10.8 us at 50 MHz).
REQ-005 Parameter CNT_W, default 18, per-channel counter width.
REQ-006 sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 trigger  input  1  single-cycle strobe that starts all enabled channels.
REQ-009 ch_enable  input  NUM_CH  per-channel enable mask.
REQ-010 ch_value  input  NUM_CH*DATA_W  packed paddle values; channel i in bits [i*DATA_W +: DATA_W].
REQ-011 pulse  output  NUM_CH  per-channel timer output, high while the channel runs.
REQ-012 done  output  NUM_CH  one-cycle strobe per channel on natural expiry.
REQ-013 busy  output  1  OR of all pulse bits.

Function
REQ-014 The block SHALL use one clock with a synchronous, active-high reset; trigger SHALL be sampled synchronously, never used as an asynchronous set.
REQ-015 On a cycle with trigger=1 and ch_enable[i]=1, channel i SHALL latch N_i = BASE_TICKS + ch_value[i]*SLOPE_TICKS, computed at CNT_W bits.
REQ-016 pulse[i] SHALL rise on the cycle after trigger is sampled and stay high for exactly N_i consecutive cycles.
REQ-017 Each channel SHALL have two states, IDLE (pulse=0) and RUN (pulse=1); IDLE->RUN on enabled trigger; RUN->IDLE when remaining count reaches zero.
REQ-018 done[i] SHALL be high for exactly one cycle, the first cycle pulse[i] is low after natural expiry.
REQ-019 A trigger during RUN SHALL reload channel i from the current ch_value; pulse[i] SHALL stay high without a gap, and no done SHALL be emitted for the aborted run.
REQ-020 A trigger with ch_enable[i]=0 SHALL leave channel i in IDLE.
REQ-021 ch_enable[i] deasserting during RUN SHALL force IDLE on the next cycle, clear the counter, and emit no done.
REQ-022 ch_value changes after trigger SHALL NOT affect a running channel.
REQ-023 The counter SHALL never wrap; decrementing SHALL stop at zero.
REQ-024 Elaboration SHALL fail if BASE_TICKS + (2^DATA_W-1)*SLOPE_TICKS exceeds 2^CNT_W-1, or if BASE_TICKS is 0.
REQ-025 busy SHALL be a combinational OR of the registered pulse bits.

Reset
REQ-026 While reset=1, all channels SHALL be IDLE, with every counter, pulse and done bit 0.
REQ-027 Reset SHALL take priority over a same-cycle trigger; that trigger is discarded.
REQ-028 Reset asserted mid-run SHALL drop pulse on the next edge and emit no done.

Structure
REQ-029 Package pdl_pkg SHALL hold the default constants: BASE_TICKS, SLOPE_TICKS, DATA_W, CNT_W and the 50 MHz tick-period note.
REQ-030 The per-channel counter/FSM SHALL be sub-module pdl_channel, instantiated NUM_CH times by a generate loop; the top level holds only value unpacking and busy.

Verification
REQ-031 Value 0 on ch0 with trigger at cycle T -> pulse[0] high during cycles T+1..T+200, and done[0] high at T+201 only.
REQ-032 Value 255 on ch1 -> pulse[1] high for exactly 137900 cycles, then a single done[1].
REQ-033 Values {10,20,30,40} with ch_enable=4'b1010 -> only ch1 (11000 cycles) and ch3 (21800 cycles) pulse; busy follows ch3.
REQ-034 Retrigger ch0 (value 0, then 1) at cycle 100 of its run -> pulse continuous, 740 cycles from the retrigger, one done.
REQ-035 Reset at cycle 50 of a run -> pulse 0 next cycle, no done; trigger and reset in the same cycle -> no pulse.
REQ-036 Drop ch_enable[2] mid-run -> pulse[2] 0 next cycle, no done; ch_value changed mid-run -> length unchanged.
